// File: rtl/genius_lfsr_prng_gen_pkg.sv
// Shared types and default parameters for the Genius LFSR colour generator.
package genius_lfsr_prng_gen_pkg;

    localparam int               DEF_LFSR_W     = 16;
    localparam logic [15:0]      DEF_TAPS       = 16'hB400;
    localparam logic [15:0]      DEF_RESET_SEED = 16'hACE1;
    localparam int               DEF_SYM_W      = 2;

    // Symbol-generation FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } prng_state_e;

    // Colour symbol at the default width, for game-side code.
    typedef logic [DEF_SYM_W-1:0] colour_t;

endpackage

// File: rtl/genius_lfsr_prng_gen_if.sv
// Symbol handshake between the game controller/colour memory and the generator.
interface genius_lfsr_prng_gen_if #(
    parameter int SYM_W = genius_lfsr_prng_gen_pkg::DEF_SYM_W
);
    logic             sym_req;
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym_out;

    // Requester/consumer side.
    modport master (
        output sym_req,
        output sym_ready,
        input  sym_valid,
        input  sym_out
    );

    // Generator side.
    modport slave (
        input  sym_req,
        input  sym_ready,
        output sym_valid,
        output sym_out
    );
endinterface

// File: rtl/genius_lfsr_prng_gen_core.sv
// Galois LFSR state register with seed loading and zero-seed lock-up protection.
// A seed load always wins over a step on the same edge.
module genius_lfsr_core
    import genius_lfsr_prng_gen_pkg::*;
#(
    parameter int                LFSR_W     = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(DEF_RESET_SEED)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [LFSR_W-1:0] seed,
    input  logic              seed_load,
    input  logic              step_en,
    output logic [LFSR_W-1:0] lfsr_state,
    output logic              lockup_fix
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              lockup_q, lockup_d;

    // Next LFSR state: seed load (zero seed replaced), else Galois step, else hold.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        lfsr_d   = lfsr_q;
        lockup_d = 1'b0;
        if (seed_load) begin
            if (seed == '0) begin
                lfsr_d   = RESET_SEED;
                lockup_d = 1'b1;
            end else begin
                lfsr_d   = seed;
            end
        end else if (step_en) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    // State and lock-up pulse registers.
    always_ff @(posedge clk or negedge rst_) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_) begin
            lfsr_q   <= RESET_SEED;
            lockup_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            lockup_q <= lockup_d;
        end
    end

    assign lfsr_state = lfsr_q;
    assign lockup_fix = lockup_q;

endmodule

// File: rtl/genius_lfsr_prng_gen.sv
// Genius colour generator top: LFSR core plus on-demand symbol FSM with a
// valid/ready handshake. Optional feature macro: GENIUS_PRNG_NODUP_EN
// (when defined, a candidate equal to the last accepted symbol is discarded).
module genius_lfsr_prng_gen
    import genius_lfsr_prng_gen_pkg::*;
#(
    parameter int                LFSR_W     = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(DEF_RESET_SEED),
    parameter int                SYM_W      = DEF_SYM_W
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic [LFSR_W-1:0]            seed,
    input  logic                         seed_load,
    input  logic                         run_en,
    genius_lfsr_prng_gen_if.slave        sym_if,
    output logic                         random_out,
    output logic [LFSR_W-1:0]            lfsr_state,
    output logic                         lockup_fix
);

    localparam int CNT_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_W - 1);

    prng_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] sh_q, sh_d;
    logic [SYM_W-1:0] sym_out_q, sym_out_d;
    logic             sym_valid_q, sym_valid_d;
    logic             step_en;
    logic             handshake;
    logic             last_bit;
    logic             cand_dup;
    logic [SYM_W:0]   sh_ext;
    logic [SYM_W-1:0] sh_next;

    genius_lfsr_core #(
        .LFSR_W     (LFSR_W),
        .TAPS       (TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .clk        (clk),
        .rst_       (rst_),
        .seed       (seed),
        .seed_load  (seed_load),
        .step_en    (step_en),
        .lfsr_state (lfsr_state),
        .lockup_fix (lockup_fix)
    );

    // Shift the current LFSR bit in at the LSB, so the first bit lands in the MSB.
    // The extra bit keeps this legal for SYM_W == 1.
    assign sh_ext    = {sh_q, lfsr_state[0]};
    assign sh_next   = sh_ext[SYM_W-1:0];
    assign handshake = sym_valid_q & sym_if.sym_ready;
    assign last_bit  = (cnt_q == CNT_LAST);

`ifdef GENIUS_PRNG_NODUP_EN
    logic [SYM_W-1:0] last_sym_q, last_sym_d;
    logic             last_vld_q, last_vld_d;

    assign cand_dup = last_vld_q && (sh_next == last_sym_q);

    // Last accepted symbol; forgotten on a new seed.
    always_comb begin
        last_sym_d = last_sym_q;
        last_vld_d = last_vld_q;
        if (handshake) begin
            last_sym_d = sym_out_q;
            last_vld_d = 1'b1;
        end
        if (seed_load) begin
            last_vld_d = 1'b0;
        end
    end

    // Last-symbol registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            last_sym_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_sym_q <= last_sym_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign cand_dup = 1'b0;
`endif

    // FSM state register and symbol datapath registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (sym_if.sym_req) state_d = GEN;
            GEN: begin
                if (seed_load)                  state_d = IDLE;
                else if (last_bit && !cand_dup) state_d = HOLD;
            end
            HOLD: begin
                if (handshake) state_d = sym_if.sym_req ? GEN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic: bit collection, symbol capture, LFSR step request.
    always_comb begin
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = sym_valid_q;
        step_en     = run_en;
        unique case (state_q)
            IDLE: begin
                if (sym_if.sym_req) begin
                    cnt_d = '0;
                    sh_d  = '0;
                end
            end
            GEN: begin
                // A seed load on this edge aborts the symbol; the core ignores the step.
                step_en = 1'b1;
                if (!seed_load) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 1'b1;
                    if (last_bit) begin
                        cnt_d = '0;
                        if (!cand_dup) begin
                            sym_out_d   = sh_next;
                            sym_valid_d = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    sym_valid_d = 1'b0;
                    if (sym_if.sym_req) begin
                        cnt_d = '0;
                        sh_d  = '0;
                    end
                end
            end
            default: begin
                sym_valid_d = 1'b0;
            end
        endcase
    end

    assign sym_if.sym_valid = sym_valid_q;
    assign sym_if.sym_out   = sym_out_q;
    assign random_out       = lfsr_state[0];

endmodule

// File: tb/tb_genius_lfsr_prng_gen.sv
// Directed, table-driven bench for genius_lfsr_prng_gen (4-bit LFSR, taps 4'hC).
module tb_genius_lfsr_prng_gen;

    logic       clk;
    logic       rst_;
    logic [3:0] seed;
    logic       seed_load;
    logic       run_en;
    logic       random_out, random1;
    logic [3:0] lfsr_state, lfsr1;
    logic       lockup_fix, lockup1;

    int n_vec = 0;
    int n_err = 0;

    genius_lfsr_prng_gen_if #(.SYM_W(2)) bus  ();
    genius_lfsr_prng_gen_if #(.SYM_W(1)) bus1 ();

    genius_lfsr_prng_gen #(
        .LFSR_W(4), .TAPS(4'hC), .RESET_SEED(4'h1), .SYM_W(2)
    ) dut (
        .clk(clk), .rst_(rst_), .seed(seed), .seed_load(seed_load), .run_en(run_en),
        .sym_if(bus), .random_out(random_out), .lfsr_state(lfsr_state),
        .lockup_fix(lockup_fix)
    );

    genius_lfsr_prng_gen #(
        .LFSR_W(4), .TAPS(4'hC), .RESET_SEED(4'h1), .SYM_W(1)
    ) dut1 (
        .clk(clk), .rst_(rst_), .seed(seed), .seed_load(seed_load), .run_en(1'b0),
        .sym_if(bus1), .random_out(random1), .lfsr_state(lfsr1),
        .lockup_fix(lockup1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       seed_load;
        logic [3:0] seed;
        logic       run_en;
        logic [3:0] exp_state;
        logic       exp_lockup;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_step(input logic [3:0] s);
        return (s >> 1) ^ (s[0] ? 4'hC : 4'h0);
    endfunction

    logic [3:0] m;
    logic       b, last, lv;
    int         zeros, waited;

    initial begin
        // Step sequence, zero seed and seed-over-run priority.
        vecs[0]  = '{1'b1, 4'b1010, 1'b0, 4'b1010, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0101, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b1110, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0111, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 1'b1, 4'b1111, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 1'b1, 4'b1011, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0};
        vecs[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b1};
        vecs[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0};
        vecs[11] = '{1'b1, 4'b0011, 1'b1, 4'b0011, 1'b0};

        rst_ = 1'b0; seed = '0; seed_load = 1'b0; run_en = 1'b0;
        bus.sym_req = 1'b0;  bus.sym_ready = 1'b0;
        bus1.sym_req = 1'b0; bus1.sym_ready = 1'b0;
        #12;
        check("rst_state",  lfsr_state,    4'h1);
        check("rst_random", random_out,    1'b1);
        check("rst_valid",  bus.sym_valid, 1'b0);
        check("rst_symout", bus.sym_out,   2'b00);
        check("rst_lockup", lockup_fix,    1'b0);
        rst_ = 1'b1;

        for (int i = 0; i < 12; i++) begin
            seed = vecs[i].seed; seed_load = vecs[i].seed_load; run_en = vecs[i].run_en;
            tick();
            check($sformatf("vec%0d_state", i),  lfsr_state, vecs[i].exp_state);
            check($sformatf("vec%0d_lockup", i), lockup_fix, vecs[i].exp_lockup);
            check($sformatf("vec%0d_random", i), random_out, vecs[i].exp_state[0]);
        end

        // Full period: back to the seed after 15 steps, never all-zero.
        seed = 4'b1010; seed_load = 1'b1; run_en = 1'b0; tick();
        seed_load = 1'b0; run_en = 1'b1; zeros = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (lfsr_state == 4'b0000) zeros++;
            if (i < 14) check("period_not_back", lfsr_state == 4'b1010, 1'b0);
        end
        check("period_zero_seen", zeros, 0);
        check("period_state",     lfsr_state, 4'b1010);
        run_en = 1'b0;

        // Symbol generation with a held consumer; sym_req in HOLD is ignored.
        seed = 4'b1010; seed_load = 1'b1; tick(); seed_load = 1'b0;
        bus.sym_ready = 1'b1; tick(); bus.sym_ready = 1'b0;
        check("ready_idle_valid", bus.sym_valid, 1'b0);
        bus.sym_req = 1'b1; tick(); bus.sym_req = 1'b0;
        check("gen_e0_valid", bus.sym_valid, 1'b0);
        tick();
        check("gen_e1_valid", bus.sym_valid, 1'b0);
        tick();
        check("gen_valid", bus.sym_valid, 1'b1);
        check("gen_symout", bus.sym_out, 2'b01);
        check("gen_state", lfsr_state, 4'b1110);
        bus.sym_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_symout", bus.sym_out, 2'b01);
            check("hold_valid", bus.sym_valid, 1'b1);
            check("hold_state", lfsr_state, 4'b1110);
        end
        bus.sym_req = 1'b0; bus.sym_ready = 1'b1; tick(); bus.sym_ready = 1'b0;
        check("accept_valid", bus.sym_valid, 1'b0);
        tick();
        check("idle_valid", bus.sym_valid, 1'b0);
        check("idle_state", lfsr_state, 4'b1110);

        // Back-to-back request on the accepting edge.
        seed = 4'b1110; seed_load = 1'b1; tick(); seed_load = 1'b0;
        bus.sym_req = 1'b1; tick(); bus.sym_req = 1'b0;
        tick(); tick();
        check("b2b_first_valid", bus.sym_valid, 1'b1);
        check("b2b_first_sym", bus.sym_out, 2'b01);
        check("b2b_first_state", lfsr_state, 4'b1111);
        bus.sym_req = 1'b1; bus.sym_ready = 1'b1; tick();
        bus.sym_req = 1'b0; bus.sym_ready = 1'b0;
        check("b2b_drop_valid", bus.sym_valid, 1'b0);
        tick();
        check("b2b_mid_valid", bus.sym_valid, 1'b0);
        tick();
        check("b2b_second_valid", bus.sym_valid, 1'b1);
        check("b2b_second_sym", bus.sym_out, 2'b11);
        check("b2b_second_state", lfsr_state, 4'b1001);
        bus.sym_ready = 1'b1; tick(); bus.sym_ready = 1'b0;

        // Abort: seed load on the first GEN edge.
        bus.sym_req = 1'b1; tick(); bus.sym_req = 1'b0;
        seed = 4'b1010; seed_load = 1'b1; tick(); seed_load = 1'b0;
        check("abort_state", lfsr_state, 4'b1010);
        check("abort_valid", bus.sym_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_idle_valid", bus.sym_valid, 1'b0);
            check("abort_idle_state", lfsr_state, 4'b1010);
        end

        // Asynchronous reset mid-GEN.
        bus.sym_req = 1'b1; tick(); bus.sym_req = 1'b0;
        tick();
        check("pre_rst_gen_state", lfsr_state, 4'b0101);
        #2 rst_ = 1'b0;
        #1;
        check("rst_gen_valid", bus.sym_valid, 1'b0);
        check("rst_gen_state", lfsr_state, 4'h1);
        #2 rst_ = 1'b1;
        tick();
        check("post_rst_idle_state", lfsr_state, 4'h1);

        // Asynchronous reset mid-HOLD.
        bus.sym_req = 1'b1; tick(); bus.sym_req = 1'b0;
        tick(); tick();
        check("pre_rst_hold_valid", bus.sym_valid, 1'b1);
        check("pre_rst_hold_sym", bus.sym_out, 2'b10);
        check("pre_rst_hold_state", lfsr_state, 4'b0110);
        #2 rst_ = 1'b0;
        #1;
        check("rst_hold_valid", bus.sym_valid, 1'b0);
        check("rst_hold_sym", bus.sym_out, 2'b00);
        check("rst_hold_state", lfsr_state, 4'h1);
        #2 rst_ = 1'b1;

        // One-bit symbols against a reference LFSR; alternation when NODUP is built in.
        seed = 4'b1010; seed_load = 1'b1; tick(); seed_load = 1'b0;
        m = 4'b1010; last = 1'b0; lv = 1'b0;
        for (int r = 0; r < 20; r++) begin
            b = m[0]; m = model_step(m);
`ifdef GENIUS_PRNG_NODUP_EN
            while (lv && b == last) begin
                b = m[0]; m = model_step(m);
            end
`endif
            bus1.sym_req = 1'b1; tick(); bus1.sym_req = 1'b0;
            waited = 0;
            while (!bus1.sym_valid && waited < 16) begin
                tick();
                waited++;
            end
            check("sym1_valid", bus1.sym_valid, 1'b1);
            check("sym1_out", bus1.sym_out, b);
            check("sym1_state", lfsr1, m);
`ifdef GENIUS_PRNG_NODUP_EN
            if (lv) check("sym1_alternate", bus1.sym_out, ~last);
`endif
            bus1.sym_ready = 1'b1; tick(); bus1.sym_ready = 1'b0;
            last = b; lv = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/genius_lfsr_prng_gen.md
Name: genius_lfsr_prng_gen

Overview:
Parametrised Galois LFSR pseudo-random generator for the Genius game. It is the next generation of the fixed 4-bit seed/colour generator.
- Generalises LFSR width, tap polynomial and colour-symbol width.
- Adds a valid/ready symbol handshake, so the game FSM can request colours on demand.
- Adds zero-seed lock-up protection.
- Sits between the game controller (requester) and the colour sequence memory (consumer).

Parameters:
LFSR_W, 16, LFSR state width (min 3).
TAPS, 16'hB400, Galois tap mask (right-shift form); must be a maximal-length polynomial for LFSR_W.
RESET_SEED, 16'hACE1, state loaded on reset and on a zero seed; must be nonzero.
SYM_W, 2, bits per colour symbol (2 = four colours); range 1..LFSR_W.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_  in  1  asynchronous active-low reset
seed  in  LFSR_W  seed value
seed_load  in  1  load seed on this edge
run_en  in  1  free-run: step LFSR every cycle while high
sym_req  in  1  request one new symbol
sym_valid  out  1  symbol available
sym_ready  in  1  consumer accepts symbol
sym_out  out  SYM_W  colour symbol
random_out  out  1  current LFSR bit 0
lfsr_state  out  LFSR_W  current LFSR state
lockup_fix  out  1  one-cycle pulse: zero seed replaced by RESET_SEED

Behaviour:
- Reset values:
  - lfsr_state = RESET_SEED.
  - state = IDLE.
  - sym_valid = 0, sym_out = 0, lockup_fix = 0.
  - random_out = RESET_SEED[0].
- LFSR step: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- random_out is combinational from lfsr_state[0].
- Priority each edge, highest first:
  1. seed_load: lfsr_state <= (seed == 0) ? RESET_SEED : seed. lockup_fix <= (seed == 0). No step this edge.
  2. GEN step.
  3. run_en step.
  4. Hold.
- lockup_fix is registered and high for exactly one cycle.
- FSM states IDLE, GEN, HOLD:
  - IDLE: on sym_req, go to GEN; clear bit counter cnt and shift register sh. LFSR steps only if run_en.
  - GEN: each edge, sh <= {sh[SYM_W-2:0], lfsr_state[0]} (for SYM_W = 1, sh <= lfsr_state[0]), the LFSR steps, and cnt++. The first collected bit ends up as the MSB of the symbol. The LFSR steps regardless of run_en. When cnt == SYM_W-1: sym_out <= the final symbol, sym_valid <= 1, go to HOLD.
  - HOLD: sym_out and sym_valid are stable. On sym_valid && sym_ready: sym_valid <= 0; if sym_req is also high, go straight to GEN (back-to-back, no IDLE bubble), else go to IDLE. LFSR steps only if run_en.
- Latency: sym_valid rises SYM_W edges after the edge that samples sym_req in IDLE.
- seed_load during GEN aborts the symbol: go to IDLE, no sym_valid.
- seed_load during HOLD keeps the held symbol and sym_valid.
- sym_req is ignored in GEN, and ignored in HOLD unless the handshake completes that cycle.
- sym_ready while sym_valid = 0 has no effect.
- Asynchronous reset mid-GEN or mid-HOLD: immediate return to reset values; any pending symbol is lost.

Optional Feature:
GENIUS_PRNG_NODUP_EN
- Defined: a registered last_sym and last_vld track the last accepted symbol. At the end of GEN, if last_vld and the candidate equals last_sym, the candidate is discarded: cnt resets to 0 and GEN continues. sym_valid does not assert for that candidate, so no colour repeats consecutively.
  - last_vld is set on handshake and cleared by reset and by seed_load.
  - With SYM_W = 1 this forces alternating symbols.
- Undefined: no comparison; symbols may repeat; no last_sym storage.

Decomposition:
- Package typedefs: prng_state_e enum {IDLE, GEN, HOLD}; default localparams for LFSR_W, TAPS, RESET_SEED, SYM_W; colour_t sized to SYM_W for game use.
- One natural sub-module, genius_lfsr_core: state register, step, seed and zero-seed logic, lockup_fix.
- The FSM and handshake stay in the top module.

Test Plan:
1. Step sequence. Setup: LFSR_W=4, TAPS=4'hC, RESET_SEED=4'h1; seed 4'b1010 + seed_load, then run_en=1. Expected: lfsr_state = 1010, 0101, 1110, 0111, 1111, 1011, 1001, 1000; state returns to 1010 after 15 steps; never 0000.
2. Zero-seed protection. Setup: seed 0 + seed_load. Expected: lfsr_state = RESET_SEED, lockup_fix high exactly 1 cycle.
3. Symbol generation. Setup: LFSR_W=4, SYM_W=2, state 1010, run_en=0; pulse sym_req. Expected: sym_valid rises 2 edges later, sym_out = 2'b01, lfsr_state = 1110. Hold sym_ready=0 for 5 cycles: sym_out stays stable; then sym_ready=1 for 1 cycle: sym_valid drops.
4. Back-to-back and abort. Back-to-back: sym_req and sym_ready both high while in HOLD → next symbol valid 2 edges later. Abort: seed_load on the first GEN cycle → no sym_valid, FSM back in IDLE.
5. Async reset. Setup: drop rst_ mid-GEN and mid-HOLD. Expected: sym_valid = 0 immediately, lfsr_state = RESET_SEED.
6. NODUP check. Setup: GENIUS_PRNG_NODUP_EN defined, SYM_W=1, 20 requests. Expected: accepted symbols strictly alternate.
